// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles big-endian words from the host link and writes instruction memory.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W    = 16,
    parameter int MAX_WORDS = 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] wa,
    output logic [31:0]       wd,
    output logic              done,
    output logic              error,
    output logic              cpu_rst_n
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_HDR, S_DATA, S_CHK, S_DONE, S_ERR} state_t;
    localparam state_t S_TAIL = S_CHK;
`else
    typedef enum logic [2:0] {S_HDR, S_DATA, S_DONE, S_ERR} state_t;
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t            state, nstate;
    logic [1:0]        byte_cnt;
    logic [ADDR_W:0]   word_cnt;
    logic [31:0]       shreg;
    logic [31:0]       count;
    logic [31:0]       assembled;
    logic              accept;
    logic              last_byte;
    logic              word_last;
    logic              collecting;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign collecting = (state == S_HDR) || (state == S_DATA);
`ifdef LOADER_CHECKSUM_EN
    assign in_ready   = (collecting || (state == S_CHK)) && !restart;
`else
    assign in_ready   = collecting && !restart;
`endif
    assign accept     = in_valid && in_ready;
    assign assembled  = {shreg[23:0], in_data};
    assign last_byte  = (byte_cnt == 2'd3);
    // Counter is one bit wider than the address so N = 2^ADDR_W terminates without wrapping.
    assign word_last  = ((32'(word_cnt) + 32'd1) == count);

    assign done      = (state == S_DONE);
    assign error     = (state == S_ERR);
    assign cpu_rst_n = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_HDR;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        if (restart) begin
            nstate = S_HDR;
        end else begin
            case (state)
                S_HDR: begin
                    if (accept && last_byte) begin
                        if (assembled > 32'(MAX_WORDS)) nstate = S_ERR;
                        else if (assembled == 32'd0)    nstate = S_TAIL;
                        else                            nstate = S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept && last_byte && word_last) nstate = S_TAIL;
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (accept) nstate = (in_data == csum) ? S_DONE : S_ERR;
                end
`endif
                default: nstate = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            word_cnt <= '0;
            shreg    <= '0;
            count    <= '0;
            we       <= 1'b0;
            wa       <= '0;
            wd       <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            we <= 1'b0;
            if (restart) begin
                byte_cnt <= '0;
                word_cnt <= '0;
                shreg    <= '0;
                count    <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum     <= '0;
`endif
            end else if (accept && collecting) begin
                shreg    <= assembled;
                byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                csum     <= csum ^ in_data;
`endif
                if (last_byte) begin
                    if (state == S_HDR) begin
                        count <= assembled;
                    end else begin
                        we       <= 1'b1;
                        wa       <= word_cnt[ADDR_W-1:0];
                        wd       <= assembled;
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a stream-level model predicts writes and status, checked every cycle.
module tb_imem_loader;
    localparam int ADDR_W    = 16;
    localparam int MAX_WORDS = 65536;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              restart;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [31:0]       wd;
    logic              done;
    logic              error;
    logic              cpu_rst_n;

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .we(we), .wa(wa), .wd(wd),
        .done(done), .error(error), .cpu_rst_n(cpu_rst_n)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int n_we        = 0;
    bit started     = 1'b0;

    // Stream-level model: bytes received since the last restart, plus resulting expectations.
    logic [7:0]  rx[$];
    logic [31:0] m_n;
    bit          m_done, m_err;
    logic [ADDR_W-1:0] exp_wa[$];
    logic [31:0]       exp_wd[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        rx.delete();
        m_n = '0; m_done = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_accept(input logic [7:0] b);
        longint n, data_end;
        logic [7:0] x;
        rx.push_back(b);
        n = rx.size();
        if (n == 4) begin
            m_n = {rx[0], rx[1], rx[2], rx[3]};
            if (longint'(m_n) > MAX_WORDS) m_err = 1'b1;
`ifndef LOADER_CHECKSUM_EN
            else if (m_n == 0) m_done = 1'b1;
`endif
        end else if (n > 4) begin
            data_end = 4 + 4 * longint'(m_n);
            if (n <= data_end) begin
                if ((n - 4) % 4 == 0) begin
                    exp_wa.push_back(ADDR_W'((n - 4) / 4 - 1));
                    exp_wd.push_back({rx[n-4], rx[n-3], rx[n-2], rx[n-1]});
`ifndef LOADER_CHECKSUM_EN
                    if (n == data_end) m_done = 1'b1;
`endif
                end
            end else begin
                x = '0;
                for (int i = 0; i < n - 1; i++) x ^= rx[i];
                if (b == x) m_done = 1'b1;
                else        m_err  = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            if (we) begin
                n_we++;
                if (exp_wd.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_we: got wa=%h wd=%h expected no write", wa, wd);
                end else begin
                    chk("wa", 32'(wa), 32'(exp_wa.pop_front()));
                    chk("wd", wd, exp_wd.pop_front());
                end
            end
            chk("done", 32'(done), 32'(m_done));
            chk("error", 32'(error), 32'(m_err));
            chk("cpu_rst_n", 32'(cpu_rst_n), 32'(m_done));
            chk("in_ready", 32'(in_ready), 32'(!(m_done || m_err) && !restart));
        end
    end

    task automatic put(input logic [7:0] b, input bit gap);
        int unsigned t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            model_accept(b);
            if (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic send_image(input logic [31:0] n, input logic [31:0] words[$],
                              input bit gap, input bit bad_chk);
        logic [7:0]  x;
        logic [31:0] w;
        x = '0;
        for (int i = 3; i >= 0; i--) begin
            put(n[i*8 +: 8], gap);
            x ^= n[i*8 +: 8];
        end
        foreach (words[k]) begin
            w = words[k];
            for (int i = 3; i >= 0; i--) begin
                put(w[i*8 +: 8], gap);
                x ^= w[i*8 +: 8];
            end
        end
`ifdef LOADER_CHECKSUM_EN
        put(bad_chk ? ~x : x, gap);
`else
        if (bad_chk) x = '0;
`endif
    endtask

    task automatic do_restart();
        restart  = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(posedge clk);
        #1;
        restart  = 1'b0;
        in_valid = 1'b0;
        model_reset();
        n_we = 0;
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
        chk("pending_writes", 32'(exp_wd.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] img2[$];
        logic [31:0] img1[$];
        logic [31:0] img0[$];
        img2 = '{32'h11223344, 32'hAABBCCDD};
        img1 = '{32'hDEADBEEF};
        img0 = {};

        rst_n = 1'b0; restart = 1'b0; in_valid = 1'b0; in_data = '0;
        model_reset();
        #1;
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_wa", 32'(wa), 32'd0);
        chk("rst_wd", wd, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        started = 1'b1;

        // Two-word image, back to back
        send_image(32'd2, img2, 1'b0, 1'b0);
        settle();
        chk("t1_writes", 32'(n_we), 32'd2);
        chk("t1_wa_hold", 32'(wa), 32'd1);
        chk("t1_wd_hold", wd, 32'hAABBCCDD);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_cpu_rst_n", 32'(cpu_rst_n), 32'd1);

        // Empty image
        do_restart();
`ifndef LOADER_CHECKSUM_EN
        for (int i = 0; i < 3; i++) put(8'h00, 1'b0);
        chk("t2_done_early", 32'(done), 32'd0);
        put(8'h00, 1'b0);
        chk("t2_done_next_cycle", 32'(done), 32'd1);
`else
        send_image(32'd0, img0, 1'b0, 1'b0);
`endif
        settle();
        chk("t2_writes", 32'(n_we), 32'd0);

        // Same two-word image with gaps between bytes
        do_restart();
        send_image(32'd2, img2, 1'b1, 1'b0);
        settle();
        chk("t3_writes", 32'(n_we), 32'd2);
        chk("t3_wd_hold", wd, 32'hAABBCCDD);
        chk("t3_done", 32'(done), 32'd1);

        // Oversize count 65537 goes to error, then recovery
        do_restart();
        put(8'h00, 1'b0); put(8'h01, 1'b0); put(8'h00, 1'b0); put(8'h01, 1'b0);
        chk("t4_error_next_cycle", 32'(error), 32'd1);
        settle();
        chk("t4_writes", 32'(n_we), 32'd0);
        chk("t4_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        do_restart();
        send_image(32'd2, img2, 1'b0, 1'b0);
        settle();
        chk("t4_recover_done", 32'(done), 32'd1);

        // Restart partway through data, then a one-word image
        do_restart();
        put(8'h00, 1'b0); put(8'h00, 1'b0); put(8'h00, 1'b0); put(8'h02, 1'b0);
        put(8'h11, 1'b0); put(8'h22, 1'b0); put(8'h33, 1'b0); put(8'h44, 1'b0);
        put(8'hAA, 1'b0); put(8'hBB, 1'b0);
        settle();
        chk("t5_partial_writes", 32'(n_we), 32'd1);
        do_restart();
        send_image(32'd1, img1, 1'b0, 1'b0);
        settle();
        chk("t5_writes", 32'(n_we), 32'd1);
        chk("t5_wa", 32'(wa), 32'd0);
        chk("t5_wd", wd, 32'hDEADBEEF);
        chk("t5_done", 32'(done), 32'd1);

`ifdef LOADER_CHECKSUM_EN
        // Explicit checksum bytes: 0x23 is correct for N=1, DEADBEEF
        do_restart();
        put(8'h00, 1'b0); put(8'h00, 1'b0); put(8'h00, 1'b0); put(8'h01, 1'b0);
        put(8'hDE, 1'b0); put(8'hAD, 1'b0); put(8'hBE, 1'b0); put(8'hEF, 1'b0);
        put(8'h23, 1'b0);
        settle();
        chk("t6_done", 32'(done), 32'd1);
        do_restart();
        put(8'h00, 1'b0); put(8'h00, 1'b0); put(8'h00, 1'b0); put(8'h01, 1'b0);
        put(8'hDE, 1'b0); put(8'hAD, 1'b0); put(8'hBE, 1'b0); put(8'hEF, 1'b0);
        put(8'h00, 1'b0);
        settle();
        chk("t6_bad_error", 32'(error), 32'd1);
        chk("t6_bad_writes", 32'(n_we), 32'd1);
        chk("t6_bad_wd", wd, 32'hDEADBEEF);
`endif

        started = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
